// File: rtl/topk_stream_sorter.sv
// Streaming top-K selector: keeps the DEPTH best keys sorted (root = worst),
// emits evicted or rejected words, and drains the store worst-to-best on flush.
module topk_stream_sorter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEY_WIDTH  = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MAX_MODE   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           busy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state, state_d;

    logic [DATA_WIDTH-1:0] arr    [DEPTH];
    logic [DATA_WIDTH-1:0] arr_d  [DEPTH];
    logic [DATA_WIDTH-1:0] arr_up [DEPTH];
    logic [DATA_WIDTH-1:0] arr_dn [DEPTH];
    logic [DEPTH-1:0]      le;
    logic [DEPTH-1:0]      le_nx;
    logic [DEPTH:0]        le_prev;

    logic [CW-1:0]         count_d;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic                  out_valid_d;
    logic                  out_last_d;
    logic                  busy_d;
    logic                  pend;
    logic                  pend_d;

    logic hs, accept, data_ok, full, evict_root, fl, can_act, go_drain;

    // "Better" is strict, so a tie with the root never displaces it.
    function automatic logic better(input logic [KEY_WIDTH-1:0] a,
                                    input logic [KEY_WIDTH-1:0] b);
        if (MAX_MODE == 0) return a > b;
        return a < b;
    endfunction

    assign in_ready   = (state == RUN) && !init && !flush && (!out_valid || out_ready);
    assign hs         = out_valid && out_ready;
    assign accept     = in_valid && in_ready;
    assign data_ok    = (in_data[DATA_WIDTH-1 -: 2] == 2'b00);
    assign full       = (count == CW'(DEPTH));
    assign evict_root = better(in_data[KEY_WIDTH-1:0], arr[0][KEY_WIDTH-1:0]);
    assign fl         = flush || pend;
    assign can_act    = (state == RUN) && !init && (!out_valid || out_ready) && !accept;
    assign go_drain   = fl && can_act && (count != '0);

    // le[i]: stored entry i is not better than the incoming word (a sorted prefix).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            le[i] = (CW'(i) < count) && !better(arr[i][KEY_WIDTH-1:0], in_data[KEY_WIDTH-1:0]);
        end
        le_nx   = le >> 1;
        le_prev = {le, 1'b1};
        arr_up[0]       = in_data;
        arr_dn[DEPTH-1] = arr[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) begin
            arr_up[i]   = arr[i-1];
            arr_dn[i-1] = arr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            RUN:   if (go_drain) state_d = DRAIN;
            DRAIN: if (init || (hs && out_last)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        arr_d       = arr;
        count_d     = count;
        out_valid_d = out_valid && !out_ready;
        out_last_d  = out_last && !hs;
        out_data_d  = out_data;
        pend_d      = pend;
        busy_d      = (state_d == DRAIN);
        if (init) begin
            count_d = '0;
            pend_d  = 1'b0;
        end else if (state == DRAIN) begin
            pend_d = 1'b0;
            if (hs) begin
                arr_d   = arr_dn;
                count_d = count - CW'(1);
                if (!out_last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = arr[1];
                    out_last_d  = (count == CW'(2));
                end
            end
        end else begin
            if (accept && data_ok) begin
                if (!full) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (le[i])           arr_d[i] = arr[i];
                        else if (le_prev[i]) arr_d[i] = in_data;
                        else                 arr_d[i] = arr_up[i];
                    end
                    count_d = count + CW'(1);
                end else begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    if (evict_root) begin
                        out_data_d = arr[0];
                        for (int i = 0; i < DEPTH; i++) begin
                            if (le_nx[i])   arr_d[i] = arr_dn[i];
                            else if (le[i]) arr_d[i] = in_data;
                            else            arr_d[i] = arr[i];
                        end
                    end else begin
                        out_data_d = in_data;
                    end
                end
            end
            // A flush seen while an eviction waits is held until the output frees up.
            if (fl && can_act) begin
                pend_d = 1'b0;
                if (go_drain) begin
                    out_valid_d = 1'b1;
                    out_data_d  = arr[0];
                    out_last_d  = (count == CW'(1));
                end
            end else begin
                pend_d = fl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            pend      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
        end else begin
            count     <= count_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
            busy      <= busy_d;
            pend      <= pend_d;
            arr       <= arr_d;
        end
    end

endmodule
